// File: rtl/link_bist_pkg.sv
// Shared types and defaults for the parallel-link built-in self-test.
package link_bist_pkg;

  localparam logic MODE_INCR = 1'b0;
  localparam logic MODE_LFSR = 1'b1;

  localparam logic [31:0] DEFAULT_SEED = 32'hA5A5A5A5;
  localparam logic [31:0] DEFAULT_TAPS = 32'h80200003;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} top_state_e;
  typedef enum logic [1:0] {T_IDLE, T_REQ, T_LOW} tx_state_e;
  typedef enum logic       {R_IDLE, R_ACK} rx_state_e;

endpackage

// File: rtl/link_pattern_gen.sv
// Test pattern source: incrementing counter or Fibonacci-style LFSR.
// Mode is captured on load so both generators stay consistent for a whole test.
module link_pattern_gen
  import link_bist_pkg::*;
#(
  parameter int                 DATA_W = 32,
  parameter logic [DATA_W-1:0]  SEED   = DATA_W'(DEFAULT_SEED),
  parameter logic [DATA_W-1:0]  TAPS   = DATA_W'(DEFAULT_TAPS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              advance_i,
  input  logic              mode_i,
  output logic [DATA_W-1:0] word_o
);

  // An all-zero LFSR would lock up, so a zero seed becomes 1 in that mode.
  localparam logic [DATA_W-1:0] LFSR_SEED = (SEED == '0) ? DATA_W'(1) : SEED;

  logic [DATA_W-1:0] word_q, word_d;
  logic              mode_q, mode_d;

  always_comb begin
    word_d = word_q;
    mode_d = mode_q;
    if (load_i) begin
      mode_d = mode_i;
      word_d = (mode_i == MODE_LFSR) ? LFSR_SEED : SEED;
    end else if (advance_i) begin
      if (mode_q == MODE_LFSR) word_d = {word_q[DATA_W-2:0], ^(word_q & TAPS)};
      else                     word_d = word_q + DATA_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q <= '0;
      mode_q <= MODE_INCR;
    end else begin
      word_q <= word_d;
      mode_q <= mode_d;
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/link_bist.sv
// Link BIST top: 4-phase TX/RX handshakes, pattern compare, watchdog and status.
// en low acts as a soft reset of everything except the synchronisers.
module link_bist
  import link_bist_pkg::*;
#(
  parameter int                 DATA_W    = 32,
  parameter int                 NUM_WORDS = 10,
  parameter int                 CNT_W     = 16,
  parameter logic [DATA_W-1:0]  SEED      = DATA_W'(DEFAULT_SEED),
  parameter logic [DATA_W-1:0]  TAPS      = DATA_W'(DEFAULT_TAPS),
  parameter int                 TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_i,
  input  logic              mode_i,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              tx_req_o,
  input  logic              tx_ack_i,
  input  logic [DATA_W-1:0] rx_data_i,
  input  logic              rx_req_i,
  output logic              rx_ack_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              pass_o,
  output logic              timeout_o,
  output logic [CNT_W-1:0]  err_count_o,
  output logic [CNT_W-1:0]  first_err_idx_o
);

  localparam int               WD_W    = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] NUM     = CNT_W'(NUM_WORDS);
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT - 1);

  logic ack_meta_q, ack_s_q, req_meta_q, req_s_q;

  top_state_e        top_q, top_d;
  tx_state_e         tx_st_q, tx_st_d;
  rx_state_e         rx_st_q, rx_st_d;
  logic [CNT_W-1:0]  tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [CNT_W-1:0]  err_q, err_d, first_err_q, first_err_d;
  logic              timeout_q, timeout_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic [DATA_W-1:0] tx_data_q, tx_data_d;
  logic              tx_req_q, tx_req_d, rx_ack_q, rx_ack_d;
  logic              gen_load, tx_adv, rx_adv;
  logic [DATA_W-1:0] tx_word, rx_word;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {ack_meta_q, ack_s_q, req_meta_q, req_s_q} <= '0;
    end else begin
      ack_meta_q <= tx_ack_i;
      ack_s_q    <= ack_meta_q;
      req_meta_q <= rx_req_i;
      req_s_q    <= req_meta_q;
    end
  end

  assign gen_load = (top_q == S_IDLE) && en_i;

  link_pattern_gen #(.DATA_W(DATA_W), .SEED(SEED), .TAPS(TAPS)) u_tx_gen (
    .clk(clk), .rst_n(rst_n), .load_i(gen_load), .advance_i(tx_adv),
    .mode_i(mode_i), .word_o(tx_word)
  );

  link_pattern_gen #(.DATA_W(DATA_W), .SEED(SEED), .TAPS(TAPS)) u_rx_gen (
    .clk(clk), .rst_n(rst_n), .load_i(gen_load), .advance_i(rx_adv),
    .mode_i(mode_i), .word_o(rx_word)
  );

  always_comb begin
    top_d       = top_q;
    tx_st_d     = tx_st_q;
    rx_st_d     = rx_st_q;
    tx_cnt_d    = tx_cnt_q;
    rx_cnt_d    = rx_cnt_q;
    err_d       = err_q;
    first_err_d = first_err_q;
    timeout_d   = timeout_q;
    wd_d        = wd_q;
    tx_data_d   = tx_data_q;
    tx_req_d    = tx_req_q;
    rx_ack_d    = rx_ack_q;
    tx_adv      = 1'b0;
    rx_adv      = 1'b0;

    if (top_q == S_IDLE) begin
      if (en_i) top_d = S_RUN;
    end else if (top_q == S_RUN) begin
      unique case (tx_st_q)
        T_IDLE: if (tx_cnt_q < NUM) begin
          tx_data_d = tx_word;
          tx_req_d  = 1'b1;
          tx_st_d   = T_REQ;
        end
        T_REQ: if (ack_s_q) begin
          tx_req_d = 1'b0;
          tx_st_d  = T_LOW;
        end
        T_LOW: if (!ack_s_q) begin
          tx_cnt_d = tx_cnt_q + CNT_W'(1);
          tx_adv   = 1'b1;
          tx_st_d  = T_IDLE;
        end
        default: tx_st_d = T_IDLE;
      endcase

      unique case (rx_st_q)
        R_IDLE: if (req_s_q) begin
          rx_ack_d = 1'b1;
          rx_st_d  = R_ACK;
          // Surplus words count as errors but do not claim a first-mismatch index.
          if ((rx_cnt_q >= NUM) || (rx_data_i != rx_word)) begin
            if (err_q != '1) err_d = err_q + CNT_W'(1);
            if ((rx_cnt_q < NUM) && (first_err_q == '1)) first_err_d = rx_cnt_q;
          end
        end
        R_ACK: if (!req_s_q) begin
          rx_ack_d = 1'b0;
          if (rx_cnt_q != '1) rx_cnt_d = rx_cnt_q + CNT_W'(1);
          rx_adv   = 1'b1;
          rx_st_d  = R_IDLE;
        end
        default: rx_st_d = R_IDLE;
      endcase

      if ((tx_st_d != tx_st_q) || (rx_st_d != rx_st_q)) wd_d = '0;
      else                                              wd_d = wd_q + WD_W'(1);

      if ((tx_cnt_q == NUM) && (rx_cnt_q == NUM) && (rx_st_q == R_IDLE)) begin
        top_d = S_DONE;
      end else if (wd_q == WD_LAST) begin
        top_d     = S_DONE;
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || !en_i) begin
      top_q       <= S_IDLE;
      tx_st_q     <= T_IDLE;
      rx_st_q     <= R_IDLE;
      tx_cnt_q    <= '0;
      rx_cnt_q    <= '0;
      err_q       <= '0;
      first_err_q <= '1;
      timeout_q   <= 1'b0;
      wd_q        <= '0;
      tx_data_q   <= '0;
      tx_req_q    <= 1'b0;
      rx_ack_q    <= 1'b0;
    end else begin
      top_q       <= top_d;
      tx_st_q     <= tx_st_d;
      rx_st_q     <= rx_st_d;
      tx_cnt_q    <= tx_cnt_d;
      rx_cnt_q    <= rx_cnt_d;
      err_q       <= err_d;
      first_err_q <= first_err_d;
      timeout_q   <= timeout_d;
      wd_q        <= wd_d;
      tx_data_q   <= tx_data_d;
      tx_req_q    <= tx_req_d;
      rx_ack_q    <= rx_ack_d;
    end
  end

  assign tx_data_o       = tx_data_q;
  assign tx_req_o        = tx_req_q;
  assign rx_ack_o        = rx_ack_q;
  assign busy_o          = (top_q == S_RUN);
  assign done_o          = (top_q == S_DONE);
  assign pass_o          = done_o && (err_q == '0) && !timeout_q;
  assign timeout_o       = timeout_q;
  assign err_count_o     = err_q;
  assign first_err_idx_o = first_err_q;

endmodule
